// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream from uart_rx_fifo to its consumer: head-of-FIFO entry plus handshake.
// valid_o is high while an entry is held; the entry is consumed on every cycle with valid_o && ready_i, and data/flags stay stable until then.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 valid_o;
  logic                 ready_i;

  modport master (output data_o, output parity_err_o, output frame_err_o, output valid_o, input ready_i);
  modport slave  (input data_o, input parity_err_o, input frame_err_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit sampling, configurable frame format
// and a receive FIFO whose head entry is presented on a ready/valid stream.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  uart_rx_fifo_if.master        rx_if,
  output logic                  overflow_o,
  output logic                  break_o,
  output logic [2:0]            state_o
);
  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0]        div_q;
  logic [3:0]           t_q, t_d;
  logic                 s7_q, s7_d, s8_q, s8_d, bit_q, bit_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d, par_zero_q, par_zero_d;
  logic                 frame_err_q, frame_err_d, stop0_zero_q, stop0_zero_d;
  logic                 push_q, push_d, brk_q, brk_d;
  logic [EW-1:0]        entry_q, entry_d;
  logic                 restart;

  logic                 tick, fall, maj, mid_tick, last_tick, par_x, is_break;

  assign tick      = (div_q == CW'(DIV - 1));
  assign fall      = rx_prev_q & ~rx_s2_q;
  assign maj       = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);
  assign mid_tick  = tick && (t_q == 4'd9);
  assign last_tick = tick && (t_q == 4'd15);
  assign par_x     = (^shift_q) ^ maj;
  // Break needs the first stop bit low; with two stop bits it was recorded one bit earlier.
  assign is_break  = (shift_q == '0) && par_zero_q &&
                     ((stop_cnt_q == 1'b0) ? ~maj : stop0_zero_q);
  assign state_o   = state_q;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    bit_d        = bit_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    par_zero_d   = par_zero_q;
    frame_err_d  = frame_err_q;
    stop0_zero_d = stop0_zero_q;
    entry_d      = entry_q;
    push_d       = 1'b0;
    brk_d        = 1'b0;
    restart      = 1'b0;

    if (tick && state_q != S_IDLE && state_q != S_BRK_WAIT) begin
      t_d = t_q + 4'd1;
      if (t_q == 4'd7) s7_d = rx_s2_q;
      if (t_q == 4'd8) s8_d = rx_s2_q;
      if (t_q == 4'd9) bit_d = maj;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d      = S_START;
          t_d          = '0;
          restart      = 1'b1;
          bit_cnt_d    = '0;
          stop_cnt_d   = 1'b0;
          par_err_d    = 1'b0;
          par_zero_d   = 1'b1;
          frame_err_d  = 1'b0;
          stop0_zero_d = 1'b0;
        end
      end
      S_START: begin
        if (last_tick) state_d = bit_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid_tick) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (last_tick) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid_tick) begin
          par_err_d  = (PARITY == 1) ? ~par_x : par_x;
          par_zero_d = ~maj;
        end
        if (last_tick) state_d = S_STOP;
      end
      S_STOP: begin
        // Decide at mid-bit of the last stop bit so a back-to-back start edge is caught.
        if (mid_tick) begin
          frame_err_d = frame_err_q | ~maj;
          if (stop_cnt_q == 1'b0) stop0_zero_d = ~maj;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            if (is_break) begin
              brk_d   = 1'b1;
              state_d = S_BRK_WAIT;
            end else begin
              push_d  = 1'b1;
              entry_d = {frame_err_q | ~maj, par_err_q, shift_q};
              state_d = S_IDLE;
            end
          end
        end
        if (last_tick) stop_cnt_d = stop_cnt_q + 1'b1;
      end
      S_BRK_WAIT: begin
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_q        <= '0;
      state_q      <= S_IDLE;
      t_q          <= '0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      bit_q        <= 1'b1;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      par_zero_q   <= 1'b1;
      frame_err_q  <= 1'b0;
      stop0_zero_q <= 1'b0;
      entry_q      <= '0;
      push_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      rx_s1_q      <= rx_i;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      div_q        <= (restart || tick) ? '0 : div_q + 1'b1;
      state_q      <= state_d;
      t_q          <= t_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      bit_q        <= bit_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      par_zero_q   <= par_zero_d;
      frame_err_q  <= frame_err_d;
      stop0_zero_q <= stop0_zero_d;
      entry_q      <= entry_d;
      push_q       <= push_d;
      brk_q        <= brk_d;
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, wr_en;
  logic [EW-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && rx_if.ready_i;
  // A pop on a full FIFO frees the slot the push lands in during the same cycle.
  assign wr_en = push_q && (!full || pop);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  assign overflow_o         = push_q && full && !pop;
  assign break_o            = brk_q;
  assign rx_if.valid_o      = !empty;
  assign rx_if.data_o       = empty ? '0 : head[DATA_BITS-1:0];
  assign rx_if.parity_err_o = !empty && head[DATA_BITS];
  assign rx_if.frame_err_o  = !empty && head[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= entry_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a configurable frame format, 16x oversampling, majority-vote sampling and a receive FIFO with a ready/valid output. It is the next-generation receive path for the icebreaker UART ALU design. It sits between the board `TX` pin and the ALU command parser, running in the 25 MHz PLL domain. Unlike the fixed 8N1 receive path, it supports 5–9 data bits, optional odd/even parity, and 1 or 2 stop bits. It also reports per-byte parity and framing errors, break conditions and FIFO overflow.

## Interface
- `CLK_HZ`, 25_000_000, clock frequency in Hz.
- `BAUD`, 115200, line rate.
- `DATA_BITS`, 8, data bits per frame, 5..9.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, 1 or 2.
- `FIFO_DEPTH`, 16, entries, power of two, ≥ 2.
- `clk`  in  1  system clock (25 MHz PLL output).
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  serial line, idle high, asynchronous to `clk`.
- `data_o`  out  DATA_BITS  head-of-FIFO data, LSB = first received bit.
- `parity_err_o`  out  1  parity error flag of the head entry.
- `frame_err_o`  out  1  stop-bit error flag of the head entry.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer accepts the head entry when `valid_o && ready_i`.
- `overflow_o`  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- `break_o`  out  1  one-cycle pulse: a break was detected.

## Operation
- **Synchroniser:** `rx_i` passes through 2 flops (reset value 1) before any other logic.
- **Tick generator:** `DIV = round(CLK_HZ / (BAUD*16))`, with a minimum of 1.
  - A counter produces a one-cycle `tick` every DIV clocks.
  - The counter free-runs in IDLE. It is restarted on start-edge detection, so tick 0 of the frame lands DIV cycles after the edge.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- **IDLE:** a synchronised 1→0 transition goes to START, with the tick counter `t` cleared.
- **Bit sampling:** every bit spans 16 ticks.
  - The bit value is the majority of the samples at ticks 7, 8 and 9.
  - The state advances after tick 15.
- **START:** if the majority value is 1, the edge is treated as a glitch and the FSM returns to IDLE. Nothing is pushed.
- **DATA:** DATA_BITS bits are shifted in LSB-first. The next state is PARITY if `PARITY != 0`, else STOP.
- **PARITY:** the error flag is computed as follows.
  - Odd: error if XOR(data, p) == 0.
  - Even: error if XOR(data, p) == 1.
- **STOP:** STOP_BITS bits; each is sampled by majority. Any 0 sets `frame_err`.
  - The push decision is made at tick 9 of the last stop bit. The FSM does not wait for tick 15, so a back-to-back start edge is not missed.
  - After that decision the FSM returns to IDLE, or goes to BREAK_WAIT on a break.
- **Break:** data all zero, parity bit (if present) zero, and first stop bit zero.
  - `break_o` pulses and nothing is pushed.
  - BREAK_WAIT holds until the synchronised line is 1, then goes to IDLE.
- **Push:** the entry {frame_err, parity_err, data} is written.
  - If the FIFO is full, the entry is dropped, `overflow_o` pulses, and FIFO contents are unchanged.
  - Errored frames are still pushed; the consumer decides what to do with them.
- **FIFO:** circular buffer of FIFO_DEPTH entries.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Outputs come combinationally from the head entry.
- **Simultaneous push and pop:**
  - When full, the pop frees a slot in the same cycle, so the push is accepted with no overflow.
  - When empty, the push lands and `valid_o` rises next cycle; there is no fall-through.
- **Reset (any time, including mid-frame):**
  - FSM → IDLE, FIFO emptied, synchroniser → 1.
  - `valid_o`, `overflow_o`, `break_o`, `parity_err_o`, `frame_err_o` = 0; `data_o` = 0.
  - A partial frame is discarded.

## Timing
- Input-to-detection latency is 2 cycles (synchroniser).
- Frame length is (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × 16 × DIV cycles.
- Push occurs in the cycle after tick 9 of the last stop bit. `valid_o` is high the cycle after that.
- `overflow_o` and `break_o` assert in the same cycle a push would have occurred.
- Pop is visible next cycle: the head advances, and `valid_o` drops if the FIFO is now empty.
- Baud tolerance is ±3 % with DIV ≥ 8.
- Accepts a new start edge from tick 10 of the last stop bit onward.

## Test plan
- **8N1 sequence:** defaults (DIV = 14, 224 cycles per bit), send 0x55, 0xA3, 0x00, each followed by a valid stop bit, with `ready_i` = 1.
  - Expect `data_o` = 0x55, 0xA3, 0x00 in order, each error flag 0.
  - `valid_o` rises 2 cycles after tick 9 of each stop bit.
- **Even parity:** `PARITY` = 2; send 0x07 with p = 1 (correct), then 0x07 with p = 0.
  - Expect two entries with `parity_err_o` = 0 and then 1.
- **Framing error, break, glitch:**
  - Send 0x3C with stop bit 0 → entry 0x3C with `frame_err_o` = 1.
  - Hold the line low for 12 bit times → a single `break_o` pulse and no push.
  - A 3-cycle low glitch on an idle line → no FSM advance past START and no push.
- **Overflow and full-boundary pop:** `ready_i` = 0, send 17 frames 0x01..0x11 into a 16-deep FIFO.
  - Expect one `overflow_o` pulse on frame 17.
  - Draining yields 0x01..0x10.
  - Repeat with a pop in the same cycle as the 17th push → no overflow, and 0x11 is retained.
- **Reset mid-frame and 9-bit, 2-stop format:**
  - Assert `rst` low during data bit 4 → all outputs 0 immediately.
  - The next clean frame is received correctly.
  - With `DATA_BITS` = 9 and `STOP_BITS` = 2, send 0x1A5 → `data_o` = 0x1A5.
  - Corrupt only the second stop bit → `frame_err_o` = 1.
